gated_mod_counter: RTL and testbench

Start/stop-gated modulo counter. It is the parametrised successor to the fixed 4-bit mod-14 SR-flop counter.
- Generalised in width and in synchroniser depth.
- Adds a runtime terminal value, up/down direction, one-shot vs free-run mode, synchronous clear, and registered wrap/done pulses.
- Sits between asynchronous control sources (buttons, external triggers) and downstream timing logic.

---
 rtl/gated_mod_counter.sv | 141 ++++++++++++++
 tb/tb_gated_mod_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gated_mod_counter.sv
// Start/stop-gated modulo counter with synchronised asynchronous controls,
// runtime terminal value, up/down direction, one-shot/free-run modes and wrap/done pulses.
module gated_mod_counter #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             oneshot,
    input  logic             dir_down,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             wrap,
    output logic             done
);

    // Synchroniser chains, previous-value flops and arming flags
    logic [SYNC_STAGES-1:0] start_sync_q;
    logic [SYNC_STAGES-1:0] stop_sync_q;
    logic                   start_prev_q;
    logic                   stop_prev_q;
    logic                   start_armed_q;
    logic                   stop_armed_q;
    logic                   start_armed_d;
    logic                   stop_armed_d;
    logic [SYNC_STAGES-1:0] fill_q;

    logic                   start_synced;
    logic                   stop_synced;
    logic                   start_edge;
    logic                   stop_edge;

    // Counter state
    logic [WIDTH-1:0]       count_q;
    logic [WIDTH-1:0]       count_d;
    logic                   running_q;
    logic                   running_d;
    logic                   wrap_q;
    logic                   wrap_d;
    logic                   done_q;
    logic                   done_d;

    logic [WIDTH-1:0]       init_val;
    logic                   at_terminal;
    logic                   terminal;

    assign start_synced = start_sync_q[SYNC_STAGES-1];
    assign stop_synced  = stop_sync_q[SYNC_STAGES-1];

    // A level held high through reset must go low once before it can count as a
    // rising edge; fill_q marks when the chain holds real pin samples, not reset zeros.
    always_comb begin
        start_armed_d = start_armed_q | (fill_q[SYNC_STAGES-1] & ~start_synced);
        stop_armed_d  = stop_armed_q  | (fill_q[SYNC_STAGES-1] & ~stop_synced);
        start_edge    = start_synced & ~start_prev_q & start_armed_q;
        stop_edge     = stop_synced  & ~stop_prev_q  & stop_armed_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_sync_q  <= '0;
            stop_sync_q   <= '0;
            start_prev_q  <= 1'b0;
            stop_prev_q   <= 1'b0;
            start_armed_q <= 1'b0;
            stop_armed_q  <= 1'b0;
            fill_q        <= '0;
        end else begin
            start_sync_q  <= {start_sync_q[SYNC_STAGES-2:0], start};
            stop_sync_q   <= {stop_sync_q[SYNC_STAGES-2:0], stop};
            start_prev_q  <= start_synced;
            stop_prev_q   <= stop_synced;
            start_armed_q <= start_armed_d;
            stop_armed_q  <= stop_armed_d;
            fill_q        <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    always_comb begin
        init_val    = dir_down ? max_val : '0;
        at_terminal = dir_down ? (count_q == '0) : (count_q >= max_val);
        terminal    = running_q & at_terminal;
    end

    // Running SR flop: stop beats one-shot completion beats start
    always_comb begin
        running_d = running_q;
        if (stop_edge) begin
            running_d = 1'b0;
        end else if (terminal && oneshot && !clear) begin
            running_d = 1'b0;
        end else if (start_edge) begin
            running_d = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        done_d  = 1'b0;
        if (clear) begin
            count_d = init_val;
        end else if (running_q) begin
            if (!terminal) begin
                count_d = dir_down ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
            end else if (oneshot) begin
                done_d = 1'b1;
            end else begin
                count_d = init_val;
                wrap_d  = 1'b1;
            end
        end else if (start_edge && !stop_edge && oneshot) begin
            // One-shot reloads on the same edge that sets running
            count_d = init_val;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
            done_q    <= done_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign wrap    = wrap_q;
    assign done    = done_q;

endmodule

// File: tb/tb_gated_mod_counter.sv
// Directed, table-driven bench for gated_mod_counter (WIDTH=4, SYNC_STAGES=2).
module tb_gated_mod_counter;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       stop;
    logic       clear;
    logic       oneshot;
    logic       dir_down;
    logic [3:0] max_val;
    logic [3:0] count;
    logic       running;
    logic       wrap;
    logic       done;

    int checks = 0;
    int errors = 0;

    gated_mod_counter #(
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .oneshot  (oneshot),
        .dir_down (dir_down),
        .max_val  (max_val),
        .count    (count),
        .running  (running),
        .wrap     (wrap),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic [3:0] exp_count;
        logic       exp_running;
        logic       exp_wrap;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(logic s, logic p, int c, logic r, logic w, logic d);
        vec_t v;
        v.start       = s;
        v.stop        = p;
        v.exp_count   = 4'(c);
        v.exp_running = r;
        v.exp_wrap    = w;
        v.exp_done    = d;
        vecs.push_back(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int c, logic r, logic w, logic d);
        checks++;
        if (count !== 4'(c) || running !== r || wrap !== w || done !== d) begin
            errors++;
            $display("FAIL %s: got count=%0d running=%b wrap=%b done=%b, want count=%0d running=%b wrap=%b done=%b",
                     name, count, running, wrap, done, c, r, w, d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        clear    = 1'b0;
        oneshot  = 1'b0;
        dir_down = 1'b0;
        max_val  = 4'd13;

        // Tests 1 and 2: free-run up to 13, then stop at 7..10 and resume
        for (int t = 0; t < 24; t++) begin
            add_vec(1'b1, 1'b0, (t < 2) ? 0 : (t - 2) % 14, t >= 2, t == 16, 1'b0);
        end
        add_vec(1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 11, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 12, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 13, 1'b1, 1'b0, 1'b0);
        add_vec(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        add_vec(1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0);

        #12;
        check("reset_state", 0, 1'b0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("idle_after_reset", 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].start;
            stop  = vecs[i].stop;
            tick();
            check($sformatf("vec%0d", i), int'(vecs[i].exp_count), vecs[i].exp_running,
                  vecs[i].exp_wrap, vecs[i].exp_done);
        end

        // Test 3: one-shot down from 5
        start = 1'b0;
        stop  = 1'b1;
        tick(); check("stop_a", 2, 1'b1, 1'b0, 1'b0);
        tick(); check("stop_b", 3, 1'b1, 1'b0, 1'b0);
        stop = 1'b0;
        tick(); check("stop_c", 4, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("stopped_hold", 4, 1'b0, 1'b0, 1'b0);
        oneshot  = 1'b1;
        dir_down = 1'b1;
        max_val  = 4'd5;
        tick(); check("cfg_no_reload", 4, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick(); check("os_lat0", 4, 1'b0, 1'b0, 1'b0);
        tick(); check("os_lat1", 4, 1'b0, 1'b0, 1'b0);
        tick(); check("os_load", 5, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            tick(); check($sformatf("os_down%0d", i), i, 1'b1, 1'b0, 1'b0);
        end
        tick(); check("os_done", 0, 1'b0, 1'b0, 1'b1);
        tick(); check("os_done_once", 0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        tick();
        tick(); check("os_reload", 5, 1'b1, 1'b0, 1'b0);

        // Test 4: simultaneous start/stop, then start while running
        repeat (4) tick();
        tick(); check("os2_zero", 0, 1'b1, 1'b0, 1'b0);
        tick(); check("os2_done", 0, 1'b0, 1'b0, 1'b1);
        oneshot  = 1'b0;
        dir_down = 1'b0;
        max_val  = 4'd13;
        start    = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        stop  = 1'b1;
        repeat (4) tick();
        check("start_stop_same", 0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        tick();
        tick(); check("fr_start", 0, 1'b1, 1'b0, 1'b0);
        tick(); check("fr_c1", 1, 1'b1, 1'b0, 1'b0);
        tick(); check("fr_c2", 2, 1'b1, 1'b0, 1'b0);
        for (int i = 3; i <= 9; i++) begin
            start = (i > 5);
            tick(); check($sformatf("restart_ignored%0d", i), i, 1'b1, 1'b0, 1'b0);
        end

        // Test 5: max_val lowered below count, then clear at terminal
        tick(); check("c10", 10, 1'b1, 1'b0, 1'b0);
        max_val = 4'd6;
        tick(); check("lowered_wrap", 0, 1'b1, 1'b1, 1'b0);
        max_val = 4'd13;
        for (int i = 1; i <= 13; i++) begin
            tick(); check($sformatf("run%0d", i), i, 1'b1, 1'b0, 1'b0);
        end
        clear = 1'b1;
        tick(); check("clear_no_wrap", 0, 1'b1, 1'b0, 1'b0);
        clear = 1'b0;
        tick(); check("after_clear", 1, 1'b1, 1'b0, 1'b0);

        // Test 6: async reset mid-count with start held high
        for (int i = 2; i <= 9; i++) tick();
        check("pre_reset", 9, 1'b1, 1'b0, 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", 0, 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(); check($sformatf("no_spurious%0d", i), 0, 1'b0, 1'b0, 1'b0);
        end
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        tick(); check("rearm_lat0", 0, 1'b0, 1'b0, 1'b0);
        tick(); check("rearm_lat1", 0, 1'b0, 1'b0, 1'b0);
        tick(); check("rearm_run", 0, 1'b1, 1'b0, 1'b0);
        tick(); check("rearm_c1", 1, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
